// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue front end: widths, command codes,
// FSM encoding and the legality check applied to every popped request.
package alu_pkg;

  localparam int OPND_W = 8;
  localparam int RES_W  = 16;
  localparam int CMD_W  = 4;
  localparam int REQ_W  = 2 * OPND_W + CMD_W;

  localparam logic [CMD_W-1:0] CMD_ADD = 4'd0;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd1;
  localparam logic [CMD_W-1:0] CMD_AND = 4'd2;
  localparam logic [CMD_W-1:0] CMD_OR  = 4'd3;
  localparam logic [CMD_W-1:0] CMD_NOT = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic [CMD_W-1:0]  cmd;
  } req_t;

  function automatic logic is_legal_cmd(input logic [CMD_W-1:0] cmd);
    return cmd <= CMD_NOT;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-drive and response signals of the issue controller.
// slave is the controller's view, master is the surrounding environment.
interface alu_issue_ctrl_if #(
  parameter int CNT_W = 16
);
  import alu_pkg::*;

  logic                req_valid_in;
  logic                req_ready_out;
  logic [OPND_W-1:0]   req_a_in;
  logic [OPND_W-1:0]   req_b_in;
  logic [CMD_W-1:0]    req_cmd_in;

  logic [OPND_W-1:0]   a_out;
  logic [OPND_W-1:0]   b_out;
  logic [CMD_W-1:0]    command_out;
  logic                enable_out;
  logic [RES_W-1:0]    alu_result_in;

  logic                rsp_valid_out;
  logic                rsp_ready_in;
  logic [RES_W-1:0]    rsp_data_out;
  logic [CMD_W-1:0]    rsp_cmd_out;
  logic                rsp_err_out;
  logic [CNT_W-1:0]    op_count_out;

  modport slave (
    input  req_valid_in, req_a_in, req_b_in, req_cmd_in,
    input  alu_result_in, rsp_ready_in,
    output req_ready_out, a_out, b_out, command_out, enable_out,
    output rsp_valid_out, rsp_data_out, rsp_cmd_out, rsp_err_out, op_count_out
  );

  modport master (
    output req_valid_in, req_a_in, req_b_in, req_cmd_in,
    output alu_result_in, rsp_ready_in,
    input  req_ready_out, a_out, b_out, command_out, enable_out,
    input  rsp_valid_out, rsp_data_out, rsp_cmd_out, rsp_err_out, op_count_out
  );

endinterface

// File: rtl/alu_req_fifo.sv
// Request FIFO holding packed {a, b, cmd} entries; head is read combinationally,
// pointers and occupancy are reset asynchronously, storage is not.
module alu_req_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = REQ_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Power-of-two depth lets the pointers wrap without compare logic.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: pops buffered requests, drives the combinational ALU for
// one cycle, captures its result and hands it downstream with a completion count.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic            clk_in,
  input  logic            rst_in,
  alu_issue_ctrl_if.slave bus
);

  state_t            state;
  req_t              head;
  logic [REQ_W-1:0]  head_bits;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  logic [OPND_W-1:0] a_q;
  logic [OPND_W-1:0] b_q;
  logic [CMD_W-1:0]  cmd_q;
  logic              en_q;
  logic              rsp_valid_q;
  logic [RES_W-1:0]  rsp_data_q;
  logic [CMD_W-1:0]  rsp_cmd_q;
  logic              rsp_err_q;
  logic [CNT_W-1:0]  op_count_q;

  // Ready stays low while reset is held so every output reads 0 in reset.
  assign bus.req_ready_out = !full && !rst_in;
  assign push              = bus.req_valid_in && bus.req_ready_out;
  assign pop               = (state == ST_IDLE) && !empty;
  assign head              = req_t'(head_bits);

  alu_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (push),
    .pop    (pop),
    .wdata  ({bus.req_a_in, bus.req_b_in, bus.req_cmd_in}),
    .rdata  (head_bits),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cmd_q       <= '0;
      en_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_cmd_q   <= '0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            if (is_legal_cmd(head.cmd)) begin
              a_q   <= head.a;
              b_q   <= head.b;
              cmd_q <= head.cmd;
              en_q  <= 1'b1;
              state <= ST_ISSUE;
            end else begin
              // Illegal commands never reach the ALU; answer directly.
              rsp_data_q  <= '0;
              rsp_cmd_q   <= head.cmd;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state       <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          rsp_data_q  <= bus.alu_result_in;
          rsp_cmd_q   <= cmd_q;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          en_q        <= 1'b0;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready_in) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.a_out         = a_q;
  assign bus.b_out         = b_q;
  assign bus.command_out   = cmd_q;
  assign bus.enable_out    = en_q;
  assign bus.rsp_valid_out = rsp_valid_q;
  assign bus.rsp_data_out  = rsp_data_q;
  assign bus.rsp_cmd_out   = rsp_cmd_q;
  assign bus.rsp_err_out   = rsp_err_q;
  assign bus.op_count_out  = op_count_q;

endmodule
